// File: rtl/bht_predictor_pkg.sv
// Shared branch-prediction constants: 2-bit counter encodings and BHT defaults.
// The BTB uses the same PC index slice, so it imports BHT_INDEX_W from here.
package bht_predictor_pkg;

    localparam logic [1:0] CNT_SN = 2'b00;
    localparam logic [1:0] CNT_WN = 2'b01;
    localparam logic [1:0] CNT_WT = 2'b10;
    localparam logic [1:0] CNT_ST = 2'b11;

    localparam int         BHT_INDEX_W  = 6;
    localparam logic [1:0] BHT_CNT_INIT = CNT_WN;

endpackage

// File: rtl/bht_predictor_if.sv
// IF-stage lookup and EX-stage resolve signals between the pipeline and the BHT.
interface bht_predictor_if;

    logic [31:0] if_pc;
    logic        pred_taken;
    logic        ex_br;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic        ex_pred_taken;
    logic        mispredict;

    modport master (
        output if_pc, ex_br, ex_valid, ex_pc, ex_taken, ex_pred_taken,
        input  pred_taken, mispredict
    );

    modport slave (
        input  if_pc, ex_br, ex_valid, ex_pc, ex_taken, ex_pred_taken,
        output pred_taken, mispredict
    );

endinterface

// File: rtl/bht_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_counter2
    import bht_predictor_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       taken,
    output logic [1:0] nxt
);

    always_comb begin
        nxt = cur;
        if (taken) begin
            if (cur != CNT_ST) nxt = cur + 2'd1;
        end else begin
            if (cur != CNT_SN) nxt = cur - 2'd1;
        end
    end

endmodule

// File: rtl/bht_predictor.sv
// Branch History Table: combinational IF-stage prediction, EX-stage training,
// mispredict flag and saturating branch/miss statistics.
module bht_predictor
    import bht_predictor_pkg::*;
#(
    parameter int         INDEX_W  = BHT_INDEX_W,
    parameter logic [1:0] CNT_INIT = BHT_CNT_INIT,
    parameter int         STAT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    bht_predictor_if.slave    bus,
    input  logic              clr_stats,
    output logic [STAT_W-1:0] br_cnt,
    output logic [STAT_W-1:0] miss_cnt
);

    localparam int ENTRIES = 1 << INDEX_W;

    // Register array rather than RAM so every entry resets asynchronously.
    logic [1:0]         tbl [ENTRIES];
    logic [INDEX_W-1:0] idx_if;
    logic [INDEX_W-1:0] idx_ex;
    logic [1:0]         cur_ex;
    logic [1:0]         nxt_ex;
    logic               upd;
    logic               unused_pc_bits;

    assign idx_if = bus.if_pc[INDEX_W+1:2];
    assign idx_ex = bus.ex_pc[INDEX_W+1:2];
    assign unused_pc_bits = ^{bus.if_pc[31:INDEX_W+2], bus.if_pc[1:0],
                              bus.ex_pc[31:INDEX_W+2], bus.ex_pc[1:0]};

    // No write-to-read bypass: a same-index update shows up the cycle after.
    assign bus.pred_taken = tbl[idx_if][1];

    assign upd            = bus.ex_br & bus.ex_valid;
    assign bus.mispredict = upd & (bus.ex_taken ^ bus.ex_pred_taken);
    assign cur_ex         = tbl[idx_ex];

    sat_counter2 u_sat_counter2 (
        .cur   (cur_ex),
        .taken (bus.ex_taken),
        .nxt   (nxt_ex)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) tbl[i] <= CNT_INIT;
        end else if (upd) begin
            tbl[idx_ex] <= nxt_ex;
        end
    end

    // Clear wins over a same-cycle update; both counters stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt   <= '0;
            miss_cnt <= '0;
        end else if (clr_stats) begin
            br_cnt   <= '0;
            miss_cnt <= '0;
        end else if (upd) begin
            if (~&br_cnt) br_cnt <= br_cnt + STAT_W'(1);
            if (bus.mispredict && ~&miss_cnt) miss_cnt <= miss_cnt + STAT_W'(1);
        end
    end

endmodule

// File: doc/bht_predictor.md
Name: bht_predictor

Overview:
- Branch History Table that works beside the BTB in the IF stage. It holds 2-bit saturating direction counters indexed by PC.
- In IF: supplies a taken/not-taken prediction for the current fetch PC. The prediction is combined with the BTB hit to pick NPC.
- From EX: receives resolved branch outcomes, trains the counters, and flags mispredictions to the hazard/flush logic.
- Keeps branch and mispredict counters for the prediction experiments.

Parameters:
- INDEX_W, 6, number of PC index bits; the table has 2^INDEX_W entries, indexed by PC[INDEX_W+1:2].
- CNT_INIT, 2'b01, counter value after reset (weakly not-taken).
- STAT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_pc  in  32  current fetch PC (CurrentPC in IF).
- pred_taken  out  1  combinational prediction for if_pc: counter[1] of the indexed entry.
- ex_br  in  1  the instruction in EX is a conditional branch (beq/bne/blt/bge/bltu/bgeu).
- ex_valid  in  1  the EX instruction is real: not a bubble, not stalled.
- ex_pc  in  32  PC of the EX instruction.
- ex_taken  in  1  resolved branch direction.
- ex_pred_taken  in  1  prediction carried down the pipeline with that instruction.
- mispredict  out  1  combinational: ex_br & ex_valid & (ex_taken != ex_pred_taken).
- br_cnt  out  STAT_W  number of resolved branches.
- miss_cnt  out  STAT_W  number of mispredicted branches.
- clr_stats  in  1  synchronous clear of br_cnt/miss_cnt.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all 2^INDEX_W counters set to CNT_INIT;
  - br_cnt = 0, miss_cnt = 0;
  - pred_taken therefore reads CNT_INIT[1] = 0.
- Read path:
  - idx_if = if_pc[INDEX_W+1:2]; bits [1:0] are ignored.
  - pred_taken = table[idx_if][1], purely combinational, zero-latency, same cycle as if_pc.
- Update is enabled when upd = ex_br & ex_valid, and happens on the rising edge. idx_ex = ex_pc[INDEX_W+1:2].
  - ex_taken=1: 00→01→10→11; 11 stays 11 (saturate).
  - ex_taken=0: 11→10→01→00; 00 stays 00 (saturate).
  - Only one entry changes per cycle.
  - upd=0 leaves the table unchanged. This covers bubbles, stalls, and non-branch jal/jalr, which the BTB alone handles.
- Read/write collision (idx_if == idx_ex in the same cycle):
  - pred_taken returns the pre-update value; there is no bypass;
  - the new value is visible to reads from the next cycle on.
- State machine per entry: states SN(00), WN(01), WT(10), ST(11), with transitions as listed above. Prediction is taken in WT and ST.
- Statistics, on the rising edge:
  - clr_stats=1 has priority: both counters go to 0, and any update in that cycle is dropped from the counts.
  - Otherwise, if upd: br_cnt += 1, and miss_cnt += 1 when mispredict.
  - Both counters saturate at all-ones; they never wrap.
  - Invariant: miss_cnt <= br_cnt.
- Flush interplay:
  - mispredict is the direction-miss request to the hazard unit;
  - the actual redirect target is computed outside this block;
  - the hazard unit must drop ex_valid on a flushed EX slot, so squashed instructions never train the table.
- Reset mid-operation: asynchronous assertion immediately forces the reset values; no partial update survives.

Decomposition:
- Shared package (branch prediction): constants for counter encodings (SN/WN/WT/ST), CNT_INIT, and default INDEX_W. The BTB reuses the same index slice.
- Sub-module sat_counter2: 2-bit saturating counter next-state function, combinational, with inputs cur and taken and output nxt. It is instantiated once on the update path.
- The table is a register array so that it can be reset asynchronously; it is not inferred as BRAM.

Test Plan:
- Reset then sample if_pc=0x00000000, 0x000000FC → pred_taken=0 for both; br_cnt=0, miss_cnt=0.
- Train ex_pc=0x00000010 taken with ex_pred_taken=0, 2 cycles, ex_br=ex_valid=1 → counter 01→10→11:
  - pred_taken at if_pc=0x10 is 1 from the cycle after the first update;
  - br_cnt=2, miss_cnt=2.
- Saturation at ex_pc=0x10:
  - 3 more taken → counter stays 11;
  - then 1 not-taken → 10, and pred_taken is still 1;
  - a 2nd not-taken → 01, and pred_taken=0.
- Aliasing with INDEX_W=6: train 0x00000004 taken twice → pred_taken at if_pc=0x00000104 is 1 (same index 1); if_pc=0x00000008 is still 0.
- Collision: if_pc=ex_pc=0x20 with counter 01, update taken → pred_taken=0 that cycle and 1 next cycle.
- Gating and stats:
  - ex_br=1, ex_valid=0 → no table or counter change;
  - clr_stats=1 together with a valid mispredicted branch → br_cnt=miss_cnt=0 next cycle, while the table still updates;
  - preload br_cnt to all-ones via a long run → br_cnt stays at 0xFFFFFFFF.
- Async reset asserted mid-cycle during an update → all outputs return to reset values before the next edge.
